// File: rtl/wb_initiator_if.sv
// Command/response handshake and Wishbone classic bus signals of wb_initiator.
// The master modport is the initiator's view; slave is the surrounding environment.
interface wb_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic [3:0]  cmd_len;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_len,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err, rsp_last, busy,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_len,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err, rsp_last, busy,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: turns single/burst commands into bus beats,
// returns one response per beat and aborts a beat that exceeds the timeout.
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_initiator_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t            state_reg,     state_next;
    logic              we_reg,        we_next;
    logic [31:0]       adr_reg,       adr_next;
    logic [31:0]       dat_reg,       dat_next;
    logic [3:0]        sel_reg,       sel_next;
    logic [3:0]        beat_reg,      beat_next;
    logic [TO_W-1:0]   to_cnt_reg,    to_cnt_next;
    logic              cyc_reg,       cyc_next;
    logic              stb_reg,       stb_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_dat_reg,   rsp_dat_next;
    logic              rsp_err_reg,   rsp_err_next;
    logic              rsp_last_reg,  rsp_last_next;

    logic              beat_end;
    logic              beat_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            sel_reg       <= '0;
            beat_reg      <= '0;
            to_cnt_reg    <= '0;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            sel_reg       <= sel_next;
            beat_reg      <= beat_next;
            to_cnt_reg    <= to_cnt_next;
            cyc_reg       <= cyc_next;
            stb_reg       <= stb_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_last_reg  <= rsp_last_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        sel_next       = sel_reg;
        beat_next      = beat_reg;
        to_cnt_next    = to_cnt_reg;
        cyc_next       = cyc_reg;
        stb_next       = stb_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_last_next  = rsp_last_reg;
        beat_end       = 1'b0;
        beat_fail      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    we_next     = bus.cmd_we;
                    adr_next    = bus.cmd_adr;
                    dat_next    = bus.cmd_dat;
                    sel_next    = bus.cmd_sel;
                    beat_next   = bus.cmd_len;
                    to_cnt_next = '0;
                    cyc_next    = 1'b1;
                    stb_next    = 1'b1;
                    state_next  = BUS;
                end
            end
            BUS: begin
                // ERR wins over a simultaneous ACK
                if (bus.wbm_err_i) begin
                    beat_end     = 1'b1;
                    beat_fail    = 1'b1;
                    rsp_dat_next = '0;
                end else if (bus.wbm_ack_i) begin
                    beat_end     = 1'b1;
                    rsp_dat_next = we_reg ? 32'h0 : bus.wbm_dat_i;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                    if (TO_EN && (to_cnt_next == TO_LIMIT)) begin
                        beat_end     = 1'b1;
                        beat_fail    = 1'b1;
                        rsp_dat_next = '0;
                    end
                end
                if (beat_end) begin
                    stb_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = beat_fail;
                    rsp_last_next  = beat_fail || (beat_reg == 4'd0);
                    // keep the bus locked between burst beats
                    cyc_next       = !(beat_fail || (beat_reg == 4'd0));
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (rsp_last_reg) begin
                        rsp_dat_next  = '0;
                        rsp_err_next  = 1'b0;
                        rsp_last_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        adr_next    = adr_reg + 32'd4;
                        beat_next   = beat_reg - 4'd1;
                        to_cnt_next = '0;
                        stb_next    = 1'b1;
                        state_next  = BUS;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_dat   = rsp_dat_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rsp_last  = rsp_last_reg;
    assign bus.wbm_cyc_o = cyc_reg;
    assign bus.wbm_stb_o = stb_reg;
    assign bus.wbm_we_o  = we_reg;
    assign bus.wbm_sel_o = sel_reg;
    assign bus.wbm_adr_o = adr_reg;
    assign bus.wbm_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: a behavioural responder plus scoreboard
// queues of expected beat addresses and responses.
module tb_wb_initiator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_initiator_if bus ();

    wb_initiator #(.TIMEOUT_CYCLES(8), .TO_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    rsp_t        exp_rsp_q[$];
    logic [31:0] exp_adr_q[$];
    logic [31:0] obs_adr_q[$];

    int          wait_states = 0;
    bit          never_ack   = 1'b0;
    bit          err_en      = 1'b0;
    logic [31:0] err_adr     = 32'h0;
    int          wcnt        = 0;
    int          stb_cycles  = 0;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Responder: drives ACK/ERR/data at the falling edge, logs each new beat.
    always @(negedge clk) begin
        if (!bus.wbm_stb_o) begin
            wcnt          = 0;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
        end else begin
            if (wcnt == 0) obs_adr_q.push_back(bus.wbm_adr_o);
            stb_cycles++;
            if (!never_ack && wcnt == wait_states) begin
                bus.wbm_ack_i = 1'b1;
                bus.wbm_err_i = err_en && (bus.wbm_adr_o == err_adr);
                bus.wbm_dat_i = rd_data(bus.wbm_adr_o);
            end else begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
            end
            wcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [3:0] len);
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("stb_latency", bus.wbm_stb_o, 1);
        chk("cyc_start", bus.wbm_cyc_o, 1);
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        chk("busy", bus.busy, 1);
        chk("bus_we", bus.wbm_we_o, we);
        chk("bus_sel", bus.wbm_sel_o, sel);
        if (we) chk("bus_dat", bus.wbm_dat_o, dat);
    endtask

    task automatic collect(input int n, input int delay);
        logic [31:0] d;
        logic        e, l;
        rsp_t        x;
        int          t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!bus.rsp_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!bus.rsp_valid) begin
                chk("rsp_valid_wait", bus.rsp_valid, 1);
                return;
            end
            d = bus.rsp_dat;
            e = bus.rsp_err;
            l = bus.rsp_last;
            chk("resp_stb_low", bus.wbm_stb_o, 0);
            chk("resp_cyc", bus.wbm_cyc_o, !l);
            for (int w = 0; w < delay; w++) begin
                @(negedge clk);
                chk("hold_valid", bus.rsp_valid, 1);
                chk("hold_dat", bus.rsp_dat, d);
                chk("hold_err", bus.rsp_err, e);
                chk("hold_last", bus.rsp_last, l);
                chk("hold_stb", bus.wbm_stb_o, 0);
                chk("hold_cyc", bus.wbm_cyc_o, !l);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_expected", exp_rsp_q.size(), 1);
                return;
            end
            x = exp_rsp_q.pop_front();
            chk("rsp_dat", d, x.dat);
            chk("rsp_err", e, x.err);
            chk("rsp_last", l, x.last);
            $display("rsp beat %0d dat=0x%08h err=%0b last=%0b", k, d, e, l);
            if (l) begin
                chk("cmd_ready_after", bus.cmd_ready, 1);
                chk("cyc_after", bus.wbm_cyc_o, 0);
            end
        end
    endtask

    task automatic check_beats();
        while (exp_adr_q.size() > 0) begin
            if (obs_adr_q.size() == 0) begin
                chk("beat_missing", obs_adr_q.size(), exp_adr_q.size());
                exp_adr_q.delete();
                return;
            end
            chk("beat_adr", obs_adr_q.pop_front(), exp_adr_q.pop_front());
        end
        chk("extra_beats", obs_adr_q.size(), 0);
        obs_adr_q.delete();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.cmd_len   = '0;
        bus.rsp_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_stb", bus.wbm_stb_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_adr", bus.wbm_adr_o, 0);
        rst_n = 1'b1;

        // 1: single write
        wait_states = 0;
        stb_cycles  = 0;
        exp_adr_q.push_back(32'h3000_0000);
        exp_rsp_q.push_back('{dat: 32'h0, err: 1'b0, last: 1'b1});
        send_cmd(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 4'd0);
        collect(1, 0);
        chk("t1_stb_cycles", stb_cycles, 1);
        check_beats();

        // 2: 4-beat read, 2 wait states
        wait_states = 2;
        stb_cycles  = 0;
        for (int k = 0; k < 4; k++) begin
            exp_adr_q.push_back(32'h3000_0000 + 32'(4 * k));
            exp_rsp_q.push_back('{dat: rd_data(32'h3000_0000 + 32'(4 * k)), err: 1'b0, last: (k == 3)});
        end
        send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'd3);
        collect(4, 0);
        chk("t2_stb_cycles", stb_cycles, 12);
        check_beats();

        // 3: same read with response backpressure
        stb_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            exp_adr_q.push_back(32'h3000_0000 + 32'(4 * k));
            exp_rsp_q.push_back('{dat: rd_data(32'h3000_0000 + 32'(4 * k)), err: 1'b0, last: (k == 3)});
        end
        send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'h3, 4'd3);
        collect(4, 5);
        chk("t3_stb_cycles", stb_cycles, 12);
        check_beats();

        // 4: timeout aborts the burst
        never_ack  = 1'b1;
        stb_cycles = 0;
        exp_adr_q.push_back(32'h3000_0040);
        exp_rsp_q.push_back('{dat: 32'h0, err: 1'b1, last: 1'b1});
        send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 4'd2);
        collect(1, 0);
        chk("t4_stb_cycles", stb_cycles, 8);
        repeat (4) @(negedge clk);
        check_beats();
        never_ack = 1'b0;

        // 5: ERR+ACK on beat 2 of a 3-beat write
        wait_states = 0;
        err_en      = 1'b1;
        err_adr     = 32'h3000_0014;
        exp_adr_q.push_back(32'h3000_0010);
        exp_adr_q.push_back(32'h3000_0014);
        exp_rsp_q.push_back('{dat: 32'h0, err: 1'b0, last: 1'b0});
        exp_rsp_q.push_back('{dat: 32'h0, err: 1'b1, last: 1'b1});
        send_cmd(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h5, 4'd2);
        collect(2, 0);
        repeat (5) @(negedge clk);
        chk("t5_stb_idle", bus.wbm_stb_o, 0);
        check_beats();
        err_en = 1'b0;

        // 6a: address wrap
        exp_adr_q.push_back(32'hFFFF_FFFC);
        exp_adr_q.push_back(32'h0000_0000);
        exp_rsp_q.push_back('{dat: rd_data(32'hFFFF_FFFC), err: 1'b0, last: 1'b0});
        exp_rsp_q.push_back('{dat: rd_data(32'h0000_0000), err: 1'b1 & 1'b0, last: 1'b1});
        send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 4'd1);
        collect(2, 0);
        check_beats();

        // 6b: reset asserted during BUS
        never_ack = 1'b1;
        send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", bus.wbm_cyc_o, 0);
        chk("rst_mid_stb", bus.wbm_stb_o, 0);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        never_ack = 1'b0;
        @(negedge clk);
        chk("rel_cmd_ready", bus.cmd_ready, 1);
        chk("rel_busy", bus.busy, 0);
        chk("rel_rsp_valid", bus.rsp_valid, 0);
        obs_adr_q.delete();
        $display("reset mid-burst done");

        // recovery: single write after reset
        exp_adr_q.push_back(32'h3000_0080);
        exp_rsp_q.push_back('{dat: 32'h0, err: 1'b0, last: 1'b1});
        send_cmd(1'b1, 32'h3000_0080, 32'hCAFE_F00D, 4'hC, 4'd0);
        collect(1, 0);
        check_beats();
        chk("rsp_queue_empty", exp_rsp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Wishbone classic (B4, non-pipelined) bus initiator that turns single- or multi-beat commands from a valid/ready command port into bus cycles toward any wishbone responder (e.g. wb_counter). It returns one response per beat on a valid/ready response port and enforces a per-beat timeout. It sits beside the SoC core inside chip_core as a second, test-oriented bus master, for example one driven by a pad-level command shifter.

Parameters:
TIMEOUT_CYCLES, 64, cycles STB may stay high without ACK/ERR before the beat is aborted; 0 disables the timeout
TO_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TO_W

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high together with cmd_valid
cmd_we  input  1  1=write, 0=read
cmd_adr  input  32  start byte address
cmd_dat  input  32  write data, written on every beat (fill semantics)
cmd_sel  input  4  byte selects, held for all beats
cmd_len  input  4  number of beats minus 1 (1..16 beats)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_dat  output  32  read data of the beat; 0 for writes and for failed beats
rsp_err  output  1  beat ended by ERR or by timeout
rsp_last  output  1  final response of the command
busy  output  1  command in progress (state != IDLE)
wbm_cyc_o  output  1  wishbone CYC
wbm_stb_o  output  1  wishbone STB
wbm_we_o  output  1  wishbone WE
wbm_sel_o  output  4  wishbone SEL
wbm_adr_o  output  32  wishbone address
wbm_dat_o  output  32  wishbone write data
wbm_dat_i  input  32  wishbone read data
wbm_ack_i  input  1  wishbone ACK
wbm_err_i  input  1  wishbone ERR

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0 except cmd_ready=1. Address, data and counters are cleared.
- States: IDLE, BUS, RESP. All outputs are registered except cmd_ready, which is high exactly when state=IDLE.
- IDLE: on the edge where cmd_valid&cmd_ready is high, latch we/adr/dat/sel/len, set beat counter = cmd_len, and move to BUS. CYC=STB=1 in the next cycle. Command-to-STB latency is 1 cycle.
- BUS: wbm_cyc_o=wbm_stb_o=1. WE/SEL/ADR/DAT stay stable for the whole beat. The bus is sampled every edge:
  - ERR=1: beat fails with rsp_err=1. ERR has priority over a simultaneous ACK.
  - ACK=1: beat succeeds. On reads, capture wbm_dat_i into rsp_dat.
  - Neither asserted: increment the timeout counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES (STB high that many cycles), the beat fails with rsp_err=1 and rsp_dat=0.
  - On beat end: STB=0 next cycle, rsp_valid=1, go to RESP. rsp_last=1 if beat counter==0 or the beat failed. CYC drops together with STB when rsp_last=1; otherwise CYC stays high through RESP, so the bus is locked for the burst.
- RESP: rsp_valid and its fields are held stable until rsp_ready. On the handshake edge:
  - rsp_last=1: go to IDLE; cmd_ready is high in the following cycle.
  - otherwise: adr += 4 (modulo 2^32, wrapping 0xFFFFFFFC -> 0x00000000), decrement beat counter, clear timeout counter, go to BUS with STB=1 next cycle.
- Throughput: best case 2 cycles per beat (1 STB cycle with ACK in the same cycle, plus 1 RESP cycle with rsp_ready high).
- ACK/ERR sampled while STB=0 are ignored.
- Failed beats abort the remainder of the burst. No further STB is issued for that command.
- New commands are not accepted while busy. cmd_valid is ignored outside IDLE.
- Reset mid-burst: CYC/STB drop immediately (async), and any pending response is discarded.

Test Plan:
1. Single write: cmd we=1 adr=0x3000_0000 dat=0xDEADBEEF sel=0xF len=0, responder ACKs in the 1st STB cycle. Expect STB high exactly 1 cycle, one response rsp_err=0 rsp_last=1, CYC low afterwards, cmd_ready high 1 cycle after the handshake.
2. 4-beat read: adr=0x3000_0000 len=3, responder returns adr-dependent data with 2 wait states. Expect ADR 0x..00, 0x..04, 0x..08, 0x..0C, matching rsp_dat, rsp_last only on the 4th beat, and CYC continuously high across all beats.
3. Response backpressure: same read with rsp_ready low for 5 cycles per beat. Expect rsp fields stable, STB low and CYC high while waiting, and no extra bus beats.
4. Timeout: TIMEOUT_CYCLES=8, responder never ACKs, len=2. Expect STB high exactly 8 cycles, a single response with rsp_err=1 rsp_dat=0 rsp_last=1, then CYC low.
5. ERR and ACK together on beat 2 of a 3-beat write. Expect the beat-2 response to carry rsp_err=1 rsp_last=1, and no beat 3.
6. Wrap and reset: read at adr=0xFFFF_FFFC with len=1. Expect the 2nd ADR to be 0x0000_0000. Separately, assert rst_n low during BUS; expect CYC/STB=0 the same cycle and cmd_ready=1 after release.
